// File: rtl/clk_gate_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// clk_gate_pkg
// Shared definitions for clock-gating controllers: the FSM state encoding
// (also driven on the debug state output), its width and the smallest legal
// wake latency (two synchroniser stages plus the ICG).
// ----------------------------------------------------------------------------
package clk_gate_pkg;

    localparam int CG_STATE_W  = 2;
    localparam int CG_MIN_WAKE = 3;

    localparam logic [CG_STATE_W-1:0] CG_OFF  = 2'd0;
    localparam logic [CG_STATE_W-1:0] CG_WAKE = 2'd1;
    localparam logic [CG_STATE_W-1:0] CG_ON   = 2'd2;

    // Encoding 3 is unused; controllers treat it as illegal and recover to ON.
    typedef enum logic [CG_STATE_W-1:0] {
        ST_OFF  = CG_OFF,
        ST_WAKE = CG_WAKE,
        ST_ON   = CG_ON
    } cg_state_e;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// ----------------------------------------------------------------------------
// clk_gate_ctrl_if
// Requester/status bundle between a gated domain and its clk_gate_ctrl.
//   req       master->slave  per-requester pending work (level)
//   busy      master->slave  gated domain still working
//   force_on  master->slave  keep the clock running
//   active    slave->master  request to the async gating cell
//   clk_ready slave->master  gated clock guaranteed running
//   state_o   slave->master  controller FSM state (debug)
//   gated_cnt slave->master  cycles spent gated (CLK_GATE_CTRL_STAT_EN only)
//
// Handshake: a requester raises its req bit and holds it until it sees
// clk_ready=1 on a clock edge; only then may it drop req. clk_ready is never
// 1 unless the gated clock is running, so a requester that sees it may start
// using the gated domain in that cycle.
// ----------------------------------------------------------------------------
interface clk_gate_ctrl_if #(
    parameter int REQ_NUM = 4
);
    logic [REQ_NUM-1:0]                  req;
    logic                                busy;
    logic                                force_on;
    logic                                active;
    logic                                clk_ready;
    logic [clk_gate_pkg::CG_STATE_W-1:0] state_o;
`ifdef CLK_GATE_CTRL_STAT_EN
    logic [31:0]                         gated_cnt;

    modport master (output req, busy, force_on,
                    input  active, clk_ready, state_o, gated_cnt);
    modport slave  (input  req, busy, force_on,
                    output active, clk_ready, state_o, gated_cnt);
`else
    modport master (output req, busy, force_on,
                    input  active, clk_ready, state_o);
    modport slave  (input  req, busy, force_on,
                    output active, clk_ready, state_o);
`endif
endinterface

// File: rtl/clk_gate_ctrl_cnt.sv
// ----------------------------------------------------------------------------
// cg_down_counter
// Loadable down counter that saturates at zero (never wraps).
//   clk, rst     clock, synchronous active-high reset (value <= RST_VAL)
//   i_load       load i_load_val (has priority over i_dec)
//   i_load_val   value to load
//   i_dec        decrement by one; ignored when already zero
//   o_value      current count
//   o_zero       count == 0
// ----------------------------------------------------------------------------
module cg_down_counter #(
    parameter int                CNT_W   = 8,
    parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= RST_VAL;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec && (r_value != '0)) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);
endmodule

// File: rtl/clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// clk_gate_ctrl
// Activity monitor and gating FSM on the free-running raw clock. Drives the
// `active` request of the downstream async gating cell and tells requesters
// when the gated clock is usable. An idle hysteresis (IDLE_CYCLES) avoids
// clock chatter; a wake count (WAKE_CYCLES) covers synchroniser + ICG latency.
//   clk   raw clock (same net as the gating cell's raw clock)
//   rst   synchronous, active-high reset
//   bus   clk_gate_ctrl_if.slave: req/busy/force_on in;
//         active/clk_ready/state_o (and gated_cnt) out, all registered
// Optional feature macro: CLK_GATE_CTRL_STAT_EN adds gated_cnt, a saturating
// count of cycles spent in OFF, cleared only by reset.
// ----------------------------------------------------------------------------
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int REQ_NUM     = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    clk_gate_ctrl_if.slave bus
);
    // Parameter sanity, caught at elaboration.
    if (REQ_NUM < 1) begin : g_chk_req
        $error("clk_gate_ctrl: REQ_NUM must be >= 1");
    end
    if (WAKE_CYCLES < CG_MIN_WAKE) begin : g_chk_wake_min
        $error("clk_gate_ctrl: WAKE_CYCLES below synchroniser+ICG latency");
    end
    if (((IDLE_CYCLES >> CNT_W) != 0) || ((WAKE_CYCLES >> CNT_W) != 0)) begin : g_chk_cnt_w
        $error("clk_gate_ctrl: CNT_W too narrow for IDLE_CYCLES/WAKE_CYCLES");
    end

    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);

    cg_state_e        r_state;
    logic             r_active;
    logic             r_clk_ready;

    logic             w_any_act;
    logic             w_wake_req;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_value;
    logic             w_cnt_zero;
    logic             w_cnt_unused;

    assign w_any_act  = (|bus.req) | bus.busy | bus.force_on;
    // busy alone keeps ON alive but never wakes a gated domain.
    assign w_wake_req = (|bus.req) | bus.force_on;

    // One counter serves both the idle hysteresis (ON) and the wake delay
    // (WAKE); the load value is chosen by state.
    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = IDLE_LD;
        w_cnt_dec      = 1'b0;
        case (r_state)
            ST_ON: begin
                if (w_any_act) begin
                    w_cnt_load = 1'b1;
                end else begin
                    w_cnt_dec  = 1'b1;
                end
            end
            ST_OFF: begin
                if (w_wake_req) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = WAKE_LD;
                end
            end
            ST_WAKE: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                end else begin
                    w_cnt_dec  = 1'b1;
                end
            end
            default: begin
                w_cnt_load = 1'b1;
            end
        endcase
    end

    cg_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (IDLE_LD)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_value    (w_cnt_value),
        .o_zero     (w_cnt_zero)
    );

    // Only the zero flag steers the FSM; the raw count is not needed here.
    assign w_cnt_unused = ^w_cnt_value;

    // active/clk_ready are registered alongside the state so they change on
    // the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ON;
            r_active    <= 1'b1;
            r_clk_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_ON: begin
                    // Activity in the expiry cycle wins: the counter reloads.
                    if (!w_any_act && w_cnt_zero) begin
                        r_state     <= ST_OFF;
                        r_active    <= 1'b0;
                        r_clk_ready <= 1'b0;
                    end
                end
                ST_OFF: begin
                    if (w_wake_req) begin
                        r_state  <= ST_WAKE;
                        r_active <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // Committed once started: dropped req does not abort.
                    if (w_cnt_zero) begin
                        r_state     <= ST_ON;
                        r_clk_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_ON;
                    r_active    <= 1'b1;
                    r_clk_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.active    = r_active;
    assign bus.clk_ready = r_clk_ready;
    assign bus.state_o   = r_state;

`ifdef CLK_GATE_CTRL_STAT_EN
    logic [31:0] r_gated_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gated_cnt <= '0;
        end else if ((r_state == ST_OFF) && (r_gated_cnt != 32'hFFFF_FFFF)) begin
            r_gated_cnt <= r_gated_cnt + 32'd1;
        end
    end

    assign bus.gated_cnt = r_gated_cnt;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_gate_ctrl
// Self-checking bench for clk_gate_ctrl (REQ_NUM=4, IDLE_CYCLES=16,
// WAKE_CYCLES=4). A behavioural model tracks the controller in terms of
// "idle streak length" and "age of the current wake-up" and predicts
// active/clk_ready/state_o (and gated_cnt when CLK_GATE_CTRL_STAT_EN is set)
// after every edge. Directed scenarios are followed by randomized segments.
// ----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

    localparam int REQ_NUM     = 4;
    localparam int IDLE_CYCLES = 16;
    localparam int WAKE_CYCLES = 4;
    localparam int CNT_W       = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_gate_ctrl_if #(.REQ_NUM(REQ_NUM)) bus ();

    clk_gate_ctrl #(
        .REQ_NUM     (REQ_NUM),
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 = gated, 1 = waking, 2 = running (also the debug encoding).
    int     m_mode       = 2;
    int     m_idle_run   = 0;   // consecutive idle cycles observed while running
    int     m_wake_age   = 0;   // edges since the wake-up began
    longint m_off_cycles = 0;   // edges that started in the gated mode

    function automatic void model_edge(input logic [REQ_NUM-1:0] rq, input logic b,
                                       input logic f, input logic r);
        if (r) begin
            m_mode       = 2;
            m_idle_run   = 0;
            m_wake_age   = 0;
            m_off_cycles = 0;
            return;
        end
        if (m_mode == 0) m_off_cycles++;
        case (m_mode)
            2: begin
                if ((rq != 0) || b || f) begin
                    m_idle_run = 0;
                end else begin
                    m_idle_run++;
                    // Gating happens on the (IDLE_CYCLES+1)-th idle cycle.
                    if (m_idle_run > IDLE_CYCLES) m_mode = 0;
                end
            end
            0: begin
                if ((rq != 0) || f) begin
                    m_mode     = 1;
                    m_wake_age = 0;
                end
            end
            default: begin
                m_wake_age++;
                if (m_wake_age >= WAKE_CYCLES) begin
                    m_mode     = 2;
                    m_idle_run = 0;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] exp_gated();
        return (m_off_cycles > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_off_cycles[31:0];
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge: drive inputs, let one posedge happen, then compare
    // the DUT against the model at the following negedge.
    task automatic step(input logic [REQ_NUM-1:0] rq, input logic b,
                        input logic f, input logic r);
        bus.req      = rq;
        bus.busy     = b;
        bus.force_on = f;
        rst          = r;
        @(posedge clk);
        model_edge(rq, b, f, r);
        @(negedge clk);
        check_val("active",    {31'd0, bus.active},    {31'd0, (m_mode != 0)});
        check_val("clk_ready", {31'd0, bus.clk_ready}, {31'd0, (m_mode == 2)});
        check_val("state_o",   {30'd0, bus.state_o},   32'(m_mode));
`ifdef CLK_GATE_CTRL_STAT_EN
        check_val("gated_cnt", bus.gated_cnt, exp_gated());
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        bus.req      = '0;
        bus.busy     = 1'b0;
        bus.force_on = 1'b0;
        @(negedge clk);

        // Reset state.
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        check_val("rst_state", {30'd0, bus.state_o}, 32'd2);

        // 1: idle after reset -> running through cycle 16, gated at 17.
        for (int i = 1; i <= 17; i++) begin
            step('0, 1'b0, 1'b0, 1'b0);
            if (i == 16) check_val("t1_active_c16", {31'd0, bus.active}, 32'd1);
        end
        check_val("t1_off_c17", {30'd0, bus.state_o}, 32'd0);

        // 2: one-cycle req[2] pulse; clk_ready exactly WAKE_CYCLES after active.
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        check_val("t2_active_rise", {31'd0, bus.active}, 32'd1);
        lat = 0;
        while (!bus.clk_ready && lat < 20) begin
            step('0, 1'b0, 1'b0, 1'b0);
            lat++;
        end
        check_val("t2_wake_latency", 32'(lat), 32'(WAKE_CYCLES));
        idle(17);
        check_val("t2_back_off", {30'd0, bus.state_o}, 32'd0);

        // 3: req toggling every 10 cycles keeps the clock on.
        for (int i = 0; i < 80; i++) begin
            step(((i / 10) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        check_val("t3_still_on", {30'd0, bus.state_o}, 32'd2);

        // 4: busy alone never wakes; busy at counter==1 reloads.
        idle(20);
        for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0, 1'b0);
        check_val("t4_busy_no_wake", {31'd0, bus.active}, 32'd0);
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        idle(WAKE_CYCLES);
        idle(IDLE_CYCLES - 1);
        step('0, 1'b1, 1'b0, 1'b0);
        idle(IDLE_CYCLES);
        check_val("t4_reload_on", {30'd0, bus.state_o}, 32'd2);
        idle(1);
        check_val("t4_then_off", {30'd0, bus.state_o}, 32'd0);

        // 5: force_on wakes and holds; release gates after 17 idle cycles.
        for (int i = 0; i < 100; i++) step('0, 1'b0, 1'b1, 1'b0);
        check_val("t5_forced_on", {31'd0, bus.active}, 32'd1);
        idle(16);
        check_val("t5_on_c16", {31'd0, bus.active}, 32'd1);
        idle(1);
        check_val("t5_off_c17", {31'd0, bus.active}, 32'd0);

        // 6: reset in WAKE with counter at 2 -> running next edge.
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        check_val("t6_rst_ready", {31'd0, bus.clk_ready}, 32'd1);
        idle(20);
        // Reset while gated with req pending: reset wins.
        step(4'b0001, 1'b0, 1'b0, 1'b1);
        check_val("t6_rst_vs_req", {30'd0, bus.state_o}, 32'd2);

        // Randomized segments of held input patterns.
        for (int seg = 0; seg < 80; seg++) begin
            int                 len;
            int                 kind;
            logic [REQ_NUM-1:0] rq;
            len  = $urandom_range(1, 30);
            kind = $urandom_range(0, 9);
            rq   = REQ_NUM'($urandom_range(1, (1 << REQ_NUM) - 1));
            if ($urandom_range(0, 24) == 0) step('0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < len; i++) begin
                case (kind)
                    5, 6:    step(rq, 1'b0, 1'b0, 1'b0);
                    7:       step('0, 1'b1, 1'b0, 1'b0);
                    8:       step('0, $urandom_range(0, 1) == 1, 1'b1, 1'b0);
                    9:       step((i == 0) ? rq : '0, 1'b0, 1'b0, 1'b0);
                    default: step('0, 1'b0, 1'b0, 1'b0);
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
